// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI mode-0 bus between two byte-oriented
// requesters (0: DivMMC SD card path, 1: second SPI device). Round-robin
// grant, chip-select ownership with optional lock, byte shifter and a
// one-cycle acknowledge with the received byte.
// Optional feature: define SPI_ARB_TIMEOUT_EN to force release of a locked
// bus after TIMEOUT owned cycles without an owner request.
module spi_bus_arbiter #(
  parameter int CLKDIV  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [7:0] tx0,
  input  logic [7:0] tx1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rx,
  output logic       owner,
  output logic       busy,
  output logic       timeout,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs0_n,
  output logic       cs1_n
);

  if (CLKDIV < 1 || TIMEOUT < 1) begin : g_param_check
    $error("spi_bus_arbiter: CLKDIV and TIMEOUT must both be >= 1");
  end

  typedef enum logic [2:0] {IDLE, OWNED, LOAD, SHIFT, DONE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);

  state_t      state, state_nxt;
  logic        owner_nxt;
  logic        last_served;
  logic [15:0] div_cnt;     // clk cycles within the current sclk half-period
  logic [3:0]  half_cnt;    // sclk half-period index; bit = half_cnt[3:1]
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        sclk_q;

  logic       half_end, last_half, sample, own_req, lock_raw, own_lock;
  logic       force_release, cs_active;
  logic [7:0] rx_in;

  assign half_end  = (div_cnt == DIV_LAST);
  assign last_half = half_end && (half_cnt == 4'd15);
  assign sample    = (state == SHIFT) && sclk_q && (div_cnt == 16'd0);
  assign rx_in     = {rx_sr[6:0], miso};
  assign own_req   = owner ? req1 : req0;
  assign lock_raw  = owner ? lock1 : lock0;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] idle_cnt;
  logic [1:0]      lock_blocked;  // lock timed out; re-armed when lockN drops
  logic            timeout_q;

  assign own_lock      = lock_raw & ~lock_blocked[owner];
  assign force_release = (state == OWNED) && !own_req && own_lock && (idle_cnt == TO_LAST);
  assign timeout       = timeout_q;

  // Owned-idle counter, timeout pulse and per-requester lock re-arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt     <= '0;
      lock_blocked <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      idle_cnt        <= (state == OWNED) ? idle_cnt + 1'b1 : '0;
      timeout_q       <= force_release;
      lock_blocked[0] <= lock0 & (lock_blocked[0] | (force_release & ~owner));
      lock_blocked[1] <= lock1 & (lock_blocked[1] | (force_release & owner));
    end
  end
`else
  assign own_lock      = lock_raw;
  assign force_release = 1'b0;
  assign timeout       = 1'b0;
`endif

  // Next-state and grant decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt = (req0 && req1) ? ~last_served : req1;
          state_nxt = LOAD;
        end
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (last_half) state_nxt = DONE;
      DONE:  state_nxt = own_lock ? OWNED : IDLE;
      OWNED: begin
        if (own_req)                          state_nxt = LOAD;
        else if (!own_lock || force_release)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (state == DONE) last_served <= owner;
    end
  end

  // Bit timing, shift registers and received-byte capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx       <= '0;
      sclk_q   <= 1'b0;
    end else if (state_nxt == LOAD) begin
      tx_sr    <= owner_nxt ? tx1 : tx0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
    end else if (state == LOAD || state == SHIFT) begin
      if (half_end) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 4'd1;
        sclk_q   <= ~half_cnt[0];
        if (half_cnt[0] && !last_half) tx_sr <= {tx_sr[6:0], 1'b0};
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
      if (sample) rx_sr <= rx_in;
      // With CLKDIV=1 the last miso sample and the end of the byte share an edge.
      if (state == SHIFT && last_half) rx <= sample ? rx_in : rx_sr;
    end
  end

  assign busy      = (state == LOAD) || (state == SHIFT) || (state == DONE);
  assign cs_active = busy || (state == OWNED);
  assign cs0_n     = ~(cs_active & ~owner);
  assign cs1_n     = ~(cs_active & owner);
  assign ack0      = (state == DONE) & ~owner;
  assign ack1      = (state == DONE) & owner;
  assign sclk      = sclk_q;
  assign mosi      = tx_sr[7];

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus random
// arbitration rounds against a transaction-level model (byte in, byte out,
// fixed latency, round-robin order) and a behavioural SPI slave.
module tb_spi_bus_arbiter;
  localparam int CLKDIV  = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 1 + 16 * CLKDIV;   // request cycle -> ack cycle

  logic       clk = 1'b0;
  logic       rst, req0, req1, lock0, lock1;
  logic [7:0] tx0, tx1, rx;
  logic       ack0, ack1, owner, busy, timeout, sclk, mosi;
  logic       miso = 1'b0;
  logic       cs0_n, cs1_n;

  spi_bus_arbiter #(.CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .tx0(tx0), .tx1(tx1), .ack0(ack0), .ack1(ack1), .rx(rx), .owner(owner),
    .busy(busy), .timeout(timeout), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs0_n(cs0_n), .cs1_n(cs1_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI mode-0 slave plus bus invariant monitors.
  logic [7:0] slave_byte [2];
  logic [7:0] cur_sb;
  logic [7:0] mosi_cap = 8'h00;
  int         bit_idx = 0;
  logic       prev_sclk = 1'b0, prev_busy = 1'b0, prev_cs0_n = 1'b1, prev_cs1_n = 1'b1;
  int         cs_overlap = 0, cs_nogap = 0, sclk_idle_bad = 0;
  int         ack0_cnt = 0, ack1_cnt = 0, cs1_high_cnt = 0;

  always @(negedge clk) begin
    cur_sb = slave_byte[owner];
    if (busy && !prev_busy) begin
      bit_idx = 0;
      miso    = cur_sb[7];
    end else if (sclk && !prev_sclk) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      bit_idx++;
    end else if (!sclk && prev_sclk && bit_idx < 8) begin
      miso = cur_sb[7 - bit_idx];
    end
    if (!cs0_n && !cs1_n) cs_overlap++;
    if ((!cs0_n && !prev_cs1_n) || (!cs1_n && !prev_cs0_n)) cs_nogap++;
    if (!busy && sclk) sclk_idle_bad++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (cs1_n) cs1_high_cnt++;
    prev_sclk  = sclk;
    prev_busy  = busy;
    prev_cs0_n = cs0_n;
    prev_cs1_n = cs1_n;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: reached cycle %0d, limit 40000 cycles", cyc);
    $fatal(1);
  end

  int model_last = 1;   // last-served requester

  function automatic logic cs_of(input int n);
    return (n == 1) ? cs1_n : cs0_n;
  endfunction

  task automatic drive_req(input int n, input logic v);
    if (n == 1) req1 = v; else req0 = v;
  endtask

  task automatic load(input int n, input logic [7:0] txb, input logic [7:0] sb);
    if (n == 1) tx1 = txb; else tx0 = txb;
    slave_byte[n] = sb;
  endtask

  task automatic wait_ack(input int n, input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if ((n == 0 && ack0) || (n == 1 && ack1)) at = cyc;
    end
    if (at < 0) check({tag, " ack within 200 cycles"}, 32'(at >= 0), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " sclk"},  sclk,  1'b0);
    check({tag, " mosi"},  mosi,  1'b0);
    check({tag, " cs0_n"}, cs0_n, 1'b1);
    check({tag, " cs1_n"}, cs1_n, 1'b1);
    check({tag, " ack"},   {ack1, ack0}, 2'b00);
    check({tag, " rx"},    rx,    8'h00);
    check({tag, " owner"}, owner, 1'b0);
    check({tag, " busy"},  busy,  1'b0);
    check({tag, " timeout"}, timeout, 1'b0);
  endtask

  // One transfer from an idle bus; checks select, latency, both data directions.
  task automatic single(input int n, input logic [7:0] txb, input logic [7:0] sb,
                        input logic exp_cs_after, input string tag, output int at);
    int t0;
    load(n, txb, sb);
    drive_req(n, 1'b1);
    t0 = cyc;
    @(negedge clk);
    check({tag, " cs low in LOAD"}, cs_of(n), 1'b0);
    wait_ack(n, tag, at);
    drive_req(n, 1'b0);
    if (at >= 0) begin
      check({tag, " latency"}, at - t0, LAT);
      check({tag, " rx"}, rx, sb);
      check({tag, " mosi byte"}, mosi_cap, txb);
      check({tag, " owner"}, owner, n);
    end
    model_last = n;
    @(negedge clk);
    check({tag, " cs after ack"}, cs_of(n), exp_cs_after);
  endtask

  // Both requesters raise req together on an idle bus.
  task automatic tie_round(input string tag);
    int t0, at, first, second;
    logic [7:0] txb [2];
    logic [7:0] sb [2];
    for (int i = 0; i < 2; i++) begin
      txb[i] = 8'($urandom);
      sb[i]  = 8'($urandom);
      load(i, txb[i], sb[i]);
    end
    req0 = 1'b1; req1 = 1'b1;
    t0 = cyc; at = -1; first = 0;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin at = cyc; first = ack1 ? 1 : 0; end
    end
    if (at < 0) begin
      check({tag, " tie ack within 200 cycles"}, 32'(at >= 0), 1);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    check({tag, " first grant"}, first, 1 - model_last);
    check({tag, " first latency"}, at - t0, LAT);
    check({tag, " first rx"}, rx, sb[first]);
    check({tag, " first mosi"}, mosi_cap, txb[first]);
    drive_req(first, 1'b0);
    model_last = first;
    second = 1 - first;
    wait_ack(second, tag, at);
    drive_req(second, 1'b0);
    if (at >= 0) begin
      check({tag, " second rx"}, rx, sb[second]);
      check({tag, " second mosi"}, mosi_cap, txb[second]);
    end
    model_last = second;
    @(negedge clk);
  endtask

  initial begin
    int at, base0, base_cs1, base_ack1, tcyc, to_seen, cs0_hi;
    logic [7:0] b1, s1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    tx0 = 8'h00; tx1 = 8'h00;
    slave_byte[0] = 8'h00; slave_byte[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ties from reset: requester 0 wins both times.
    tie_round("tie1");
    tie_round("tie2");

    single(0, 8'hA5, 8'h3C, 1'b1, "single A5", at);

    for (int r = 0; r < 40; r++) begin
      int pat = int'($urandom_range(0, 2));
      if (pat == 2) tie_round($sformatf("rnd%0d tie", r));
      else single(pat, 8'($urandom), 8'($urandom), 1'b1, $sformatf("rnd%0d req%0d", r, pat), at);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Lock retention: requester 1 keeps the bus for three bytes, req0 waits.
    lock1 = 1'b1;
    b1 = 8'($urandom); s1 = 8'($urandom);
    load(1, b1, s1);
    req1 = 1'b1;
    @(negedge clk);
    load(0, 8'h5A, 8'hC3);
    req0 = 1'b1;
    base0 = ack0_cnt; base_cs1 = cs1_high_cnt;
    for (int b = 0; b < 3; b++) begin
      wait_ack(1, $sformatf("lock byte%0d", b), at);
      if (at >= 0) begin
        check($sformatf("lock byte%0d rx", b), rx, s1);
        check($sformatf("lock byte%0d mosi", b), mosi_cap, b1);
      end
      req1 = 1'b0;
      if (b < 2) begin
        @(negedge clk);
        b1 = 8'($urandom); s1 = 8'($urandom);
        load(1, b1, s1);
        req1 = 1'b1;
      end
    end
    check("lock cs1 gap cycles", cs1_high_cnt - base_cs1, 0);
    check("lock ack0 while locked", ack0_cnt - base0, 0);
    lock1 = 1'b0;
    model_last = 1;
    wait_ack(0, "after lock", at);
    req0 = 1'b0;
    if (at >= 0) check("after lock rx", rx, 8'hC3);
    model_last = 0;
    @(negedge clk);

    // Reset in the middle of a byte for requester 1.
    load(1, 8'h96, 8'h69);
    req1 = 1'b1;
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (busy && bit_idx == 4) at = cyc;
    end
    check("reset mid: reached bit 4", 32'(at >= 0), 1);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    check_reset("reset mid");
    rst = 1'b0;
    model_last = 1;
    base_ack1 = ack1_cnt;
    repeat (40) @(negedge clk);
    check("reset mid: no ack1", ack1_cnt - base_ack1, 0);
    tie_round("post reset tie");

    // Locked owner with no further requests while req1 is pending.
    lock0 = 1'b1;
    single(0, 8'h0F, 8'hF0, 1'b0, "lock0 byte", at);
    load(1, 8'h81, 8'h18);
    req1 = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
    tcyc = -1;
    for (int i = 0; i < 60 && tcyc < 0; i++) begin
      @(negedge clk);
      if (timeout) tcyc = cyc;
    end
    check("timeout seen", 32'(tcyc >= 0), 1);
    if (tcyc >= 0) begin
      check("timeout cycle after OWNED", tcyc - (at + 1), TIMEOUT);
      check("timeout cs0_n released", cs0_n, 1'b1);
      @(negedge clk);
      check("timeout one-cycle pulse", timeout, 1'b0);
    end
    wait_ack(1, "after timeout", at);
    req1 = 1'b0;
    if (at >= 0) check("after timeout rx", rx, 8'h18);
    model_last = 1;
    @(negedge clk);
    // Lock still high but timed out: the bus must not be retained.
    single(0, 8'h3E, 8'hE3, 1'b1, "blocked lock0", at);
    lock0 = 1'b0;
`else
    to_seen = 0; cs0_hi = 0; base_ack1 = ack1_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (timeout) to_seen++;
      if (cs0_n) cs0_hi++;
    end
    check("no timeout: pulses", to_seen, 0);
    check("no timeout: cs0_n high cycles", cs0_hi, 0);
    check("no timeout: ack1 while held", ack1_cnt - base_ack1, 0);
    lock0 = 1'b0;
    wait_ack(1, "after unlock", at);
    req1 = 1'b0;
    if (at >= 0) check("after unlock rx", rx, 8'h18);
    model_last = 1;
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("cs both low cycles", cs_overlap, 0);
    check("cs handover without gap", cs_nogap, 0);
    check("sclk high while not busy", sclk_idle_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
